// File: rtl/s2mm_address_generator.sv
// Stream stage ahead of the S2MM RAM writer: registered 2-entry skid buffer that tags
// every beat with its byte address in a circular DDR ring and stops only on burst boundaries.
module s2mm_address_generator #(
  parameter int ADDR_WIDTH       = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BEAT_BYTES       = 4,
  parameter int BURST_BEATS      = 16,
  parameter int INDEX_WIDTH      = 20
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [ADDR_WIDTH-1:0]       base_address,
  input  logic [INDEX_WIDTH-1:0]      buffer_beats,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [ADDR_WIDTH-1:0]       address,
  output logic [INDEX_WIDTH-1:0]      write_index,
  output logic [15:0]                 wrap_count,
  output logic                        busy,
  output logic [1:0]                  fsm_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1; valid never
  // depends on ready, and data/address hold steady while valid=1 and ready=0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] BURST_MASK = INDEX_WIDTH'(BURST_BEATS - 1);
  localparam logic [INDEX_WIDTH-1:0] BURST_LEN  = INDEX_WIDTH'(BURST_BEATS);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_MASK  = ADDR_WIDTH'(BURST_BEATS * BEAT_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0]  STEP       = ADDR_WIDTH'(BEAT_BYTES);

  state_t                        state, next_state;
  logic [ADDR_WIDTH-1:0]         base_reg;
  logic [INDEX_WIDTH-1:0]        len_reg, len_masked, len_start;
  logic [INDEX_WIDTH-1:0]        index, index_next;
  logic                          wrap_step, aligned_next;
  logic                          in_fire, out_fire, start;
  logic [ADDR_WIDTH-1:0]         in_addr;
  logic                          skid_valid, skid_valid_next;
  logic [AXIS_TDATA_WIDTH-1:0]   skid_data;
  logic [ADDR_WIDTH-1:0]         skid_addr;

  assign in_fire    = S_AXIS_tvalid & S_AXIS_tready;
  assign out_fire   = M_AXIS_tvalid & M_AXIS_tready;
  assign start      = (state == IDLE) & enable;
  assign in_addr    = base_reg + ADDR_WIDTH'(index) * STEP;
  assign len_masked = buffer_beats & ~BURST_MASK;
  assign len_start  = (len_masked < BURST_LEN) ? BURST_LEN : len_masked;
  assign busy       = (state != IDLE) | M_AXIS_tvalid | skid_valid;
  assign fsm_state  = state;

  always_comb begin
    index_next = index;
    wrap_step  = 1'b0;
    if (in_fire) begin
      if (index == len_reg - INDEX_WIDTH'(1)) begin
        index_next = '0;
        wrap_step  = 1'b1;
      end else begin
        index_next = index + INDEX_WIDTH'(1);
      end
    end
  end

  assign aligned_next = (index_next & BURST_MASK) == '0;

  // The skid register only fills while the output register is stalled.
  always_comb begin
    if (skid_valid) skid_valid_next = ~out_fire;
    else            skid_valid_next = in_fire & M_AXIS_tvalid & ~out_fire;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN:     if (!enable) next_state = aligned_next ? IDLE : DRAIN;
      DRAIN:   if (aligned_next) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_reg      <= '0;
      len_reg       <= '0;
      index         <= '0;
      wrap_count    <= '0;
      write_index   <= '0;
      S_AXIS_tready <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      address       <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_addr     <= '0;
    end else begin
      S_AXIS_tready <= (next_state != IDLE) & ~skid_valid_next;
      skid_valid    <= skid_valid_next;
      if (start) begin
        base_reg    <= base_address & ~ADDR_MASK;
        len_reg     <= len_start;
        index       <= '0;
        wrap_count  <= '0;
        write_index <= '0;
      end else begin
        index <= index_next;
        if (wrap_step) wrap_count <= wrap_count + 16'd1;
        if (out_fire) begin
          write_index <= (write_index == len_reg - INDEX_WIDTH'(1)) ? '0
                                                                    : write_index + INDEX_WIDTH'(1);
        end
      end
      if (!M_AXIS_tvalid || out_fire) begin
        if (skid_valid) begin
          M_AXIS_tvalid <= 1'b1;
          M_AXIS_tdata  <= skid_data;
          address       <= skid_addr;
        end else if (in_fire) begin
          M_AXIS_tvalid <= 1'b1;
          M_AXIS_tdata  <= S_AXIS_tdata;
          address       <= in_addr;
        end else begin
          M_AXIS_tvalid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= S_AXIS_tdata;
        skid_addr <= in_addr;
      end
    end
  end

endmodule
